osu_frame_sequencer: RTL and testbench

- FSM that sequences the rhythm-game drawing datapath.
- Sequence: clear screen, draw background tiles, centre logo, score digits, then spawn, plot and await one 16x16 note at a time.
- On game-over, draws the game-over banner.
- Sits between top level (KEY/PS2 glue) and the datapath; produces every ld_* strobe, note coordinates and lane id.

---
 rtl/osu_pkg.sv | 34 +++
 rtl/osu_note_lfsr.sv | 48 ++++
 rtl/osu_frame_sequencer.sv | 133 +++++++++++++
 tb/tb_osu_frame_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/osu_pkg.sv
// osu_pkg: shared state encoding, screen geometry and LFSR helpers
// for the rhythm-game frame sequencer.
package osu_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CLEAR     = 4'd1,
        S_BG        = 4'd2,
        S_OSU       = 4'd3,
        S_SCORE     = 4'd4,
        S_SPAWN     = 4'd5,
        S_PLOT      = 4'd6,
        S_WAIT      = 4'd7,
        S_OVER_DRAW = 4'd8,
        S_OVER      = 4'd9
    } state_t;

    localparam int SCR_W  = 320;
    localparam int SCR_H  = 240;
    localparam int SPRITE = 16;
    localparam int COLS   = SCR_W / SPRITE;
    localparam int ROWS   = SCR_H / SPRITE;

    // A, S, D, F set-2 scancodes, indexed by lane id
    localparam logic [7:0] LANE_CODE [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};

    // x^16 + x^14 + x^13 + x^11 -> bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/osu_note_lfsr.sv
// osu_note_lfsr: note position generator; steps the LFSR on adv and
// registers an on-screen tile coordinate and lane id from the new value.
module osu_note_lfsr
    import osu_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    output logic [8:0] locX,
    output logic [7:0] locY,
    output logic [1:0] id2
);

    // An all-zero LFSR would lock up, so a zero seed falls back to 1
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0] lfsr;
    logic [15:0] lfsr_n;
    logic [4:0]  xc;
    logic [3:0]  yc;

    always_comb begin
        lfsr_n = lfsr_next(lfsr);
        xc = lfsr_n[4:0];
        if (xc >= 5'(COLS))
            xc = xc - 5'(COLS);
        yc = lfsr_n[8:5];
        if (yc >= 4'(ROWS))
            yc = 4'(ROWS - 1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr <= SEED;
            locX <= '0;
            locY <= '0;
            id2  <= '0;
        end else if (adv) begin
            lfsr <= lfsr_n;
            locX <= {xc, 4'b0000};
            locY <= {yc, 4'b0000};
            id2  <= lfsr_n[10:9];
        end
    end

endmodule

// File: rtl/osu_frame_sequencer.sv
// osu_frame_sequencer: drives the drawing datapath through clear/background/
// logo/score and per-note spawn/plot/wait. Optional macro PAUSE_EN adds pause.
module osu_frame_sequencer
    import osu_pkg::*;
#(
    parameter int          PLOT_CYCLES  = 256,
    parameter int          GO_CYCLES    = 513,
    parameter int          NOTE_TIMEOUT = 50_000_000,
    parameter int          WDOG         = 262_143,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
`ifdef PAUSE_EN
    input  logic       pause,
`endif
    input  logic       go,
    input  logic       cleared,
    input  logic       draw,
    input  logic       drewOsu,
    input  logic       drewScore,
    input  logic       done,
    input  logic       gameover,
    output logic       ld_black,
    output logic       ld_BG,
    output logic       ld_osu,
    output logic       ld_score,
    output logic       ld_coord,
    output logic       ld_plot,
    output logic       ld_gameover,
    output logic [8:0] locX,
    output logic [7:0] locY,
    output logic [1:0] id2,
    output logic       busy,
    output logic       err
);

    localparam logic [31:0] PLOT_LAST = 32'(PLOT_CYCLES - 1);
    localparam logic [31:0] GO_LAST   = 32'(GO_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = 32'(NOTE_TIMEOUT - 1);
    localparam logic [31:0] WDOG_LAST = 32'(WDOG - 1);

    state_t      state;
    state_t      state_n;
    logic [31:0] cnt;
    logic        err_n;
    logic        paused;
    logic        wd_hit;

`ifdef PAUSE_EN
    assign paused = pause && (state == S_WAIT);
`else
    assign paused = 1'b0;
`endif

    assign wd_hit = (cnt == WDOG_LAST);

    always_comb begin
        state_n = state;
        err_n   = err;
        unique case (state)
            S_IDLE: if (go) begin
                state_n = S_CLEAR;
                err_n   = 1'b0;
            end
            S_CLEAR: if (cleared) state_n = S_BG;
                     else if (wd_hit) begin state_n = S_IDLE; err_n = 1'b1; end
            S_BG:    if (draw) state_n = S_OSU;
                     else if (wd_hit) begin state_n = S_IDLE; err_n = 1'b1; end
            S_OSU:   if (drewOsu) state_n = S_SCORE;
                     else if (wd_hit) begin state_n = S_IDLE; err_n = 1'b1; end
            S_SCORE: if (drewScore) state_n = S_SPAWN;
                     else if (wd_hit) begin state_n = S_IDLE; err_n = 1'b1; end
            S_SPAWN: state_n = S_PLOT;
            S_PLOT:  if (cnt == PLOT_LAST) state_n = S_WAIT;
            S_WAIT: begin
                if (gameover)
                    state_n = S_OVER_DRAW;
                else if (done && !paused)
                    state_n = S_SCORE;
                else if (!paused && cnt == TO_LAST)
                    state_n = S_SPAWN;
            end
            S_OVER_DRAW: if (cnt == GO_LAST) state_n = S_OVER;
            S_OVER: if (go) state_n = S_CLEAR;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            ld_black    <= 1'b0;
            ld_BG       <= 1'b0;
            ld_osu      <= 1'b0;
            ld_score    <= 1'b0;
            ld_coord    <= 1'b0;
            ld_plot     <= 1'b0;
            ld_gameover <= 1'b0;
        end else begin
            state <= state_n;
            err   <= err_n;
            // One counter serves watchdog, plot, timeout and banner timing
            if (state_n != state)
                cnt <= '0;
            else if (!paused && cnt != '1)
                cnt <= cnt + 32'd1;
            busy        <= (state_n != S_IDLE) && (state_n != S_OVER);
            ld_black    <= (state_n == S_CLEAR);
            ld_BG       <= (state_n == S_BG);
            ld_osu      <= (state_n == S_OSU);
            ld_score    <= (state_n == S_SCORE);
            ld_coord    <= (state_n == S_SPAWN);
            ld_plot     <= (state_n == S_PLOT);
            ld_gameover <= (state_n == S_OVER_DRAW);
        end
    end

    osu_note_lfsr #(
        .LFSR_SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .reset(reset),
        .adv  (state_n == S_SPAWN),
        .locX (locX),
        .locY (locY),
        .id2  (id2)
    );

endmodule

// File: tb/tb_osu_frame_sequencer.sv
// tb_osu_frame_sequencer: directed-vector bench for the frame sequencer
// with shortened timing parameters.
module tb_osu_frame_sequencer;

    localparam logic [6:0] L_NONE  = 7'b0000000;
    localparam logic [6:0] L_BLACK = 7'b1000000;
    localparam logic [6:0] L_BG    = 7'b0100000;
    localparam logic [6:0] L_OSU   = 7'b0010000;
    localparam logic [6:0] L_SCORE = 7'b0001000;
    localparam logic [6:0] L_COORD = 7'b0000100;
    localparam logic [6:0] L_PLOT  = 7'b0000010;
    localparam logic [6:0] L_GO    = 7'b0000001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       go = 1'b0;
    logic [3:0] stat = 4'b0000;
    logic       done = 1'b0;
    logic       gameover = 1'b0;
    logic       ld_black, ld_BG, ld_osu, ld_score;
    logic       ld_coord, ld_plot, ld_gameover;
    logic [8:0] locX;
    logic [7:0] locY;
    logic [1:0] id2;
    logic       busy;
    logic       err;
    logic [6:0] ldv;

    int n_vec = 0;
    int n_bad = 0;

    // Hand-computed notes: LFSR ACE1 -> 59C3, B387, 670F, CE1E
    int exp_x [4] = '{48, 112, 240, 160};
    int exp_y [4] = '{224, 192, 128, 0};
    int exp_id[4] = '{0, 1, 3, 3};

    always #5 clk = ~clk;

    assign ldv = {ld_black, ld_BG, ld_osu, ld_score,
                  ld_coord, ld_plot, ld_gameover};

    osu_frame_sequencer #(
        .PLOT_CYCLES (4),
        .GO_CYCLES   (3),
        .NOTE_TIMEOUT(10),
        .WDOG        (20),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef PAUSE_EN
        .pause      (1'b0),
`endif
        .go         (go),
        .cleared    (stat[0]),
        .draw       (stat[1]),
        .drewOsu    (stat[2]),
        .drewScore  (stat[3]),
        .done       (done),
        .gameover   (gameover),
        .ld_black   (ld_black),
        .ld_BG      (ld_BG),
        .ld_osu     (ld_osu),
        .ld_score   (ld_score),
        .ld_coord   (ld_coord),
        .ld_plot    (ld_plot),
        .ld_gameover(ld_gameover),
        .locX       (locX),
        .locY       (locY),
        .id2        (id2),
        .busy       (busy),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Respond to a handshake state's strobe two cycles after it appears
    task automatic hs(input string tag, input logic [6:0] expv, input int which);
        check(tag, 32'(ldv), 32'(expv));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        stat[which] = 1'b1;
        @(negedge clk);
        stat = 4'b0000;
    endtask

    task automatic front(input string tag);
        hs({tag, "_clear"}, L_BLACK, 0);
        hs({tag, "_bg"}, L_BG, 1);
        hs({tag, "_osu"}, L_OSU, 2);
        hs({tag, "_score"}, L_SCORE, 3);
    endtask

    task automatic spawn(input string tag, input int k);
        check({tag, "_coord"}, 32'(ldv), 32'(L_COORD));
        check({tag, "_x"}, 32'(locX), 32'(exp_x[k]));
        check({tag, "_y"}, 32'(locY), 32'(exp_y[k]));
        check({tag, "_id"}, 32'(id2), 32'(exp_id[k]));
        check({tag, "_xal"}, 32'(locX % 16), 32'd0);
        check({tag, "_xrng"}, 32'(locX <= 304), 32'd1);
        check({tag, "_yrng"}, 32'(locY <= 224), 32'd1);
    endtask

    task automatic plot(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_plot"}, 32'(ldv), 32'(L_PLOT));
            check({tag, "_pbusy"}, 32'(busy), 32'd1);
        end
        @(negedge clk);
        check({tag, "_wait"}, 32'(ldv), 32'(L_NONE));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ld", 32'(ldv), 32'(L_NONE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_x", 32'(locX), 32'd0);
        check("rst_y", 32'(locY), 32'd0);
        check("rst_id", 32'(id2), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ld", 32'(ldv), 32'(L_NONE));
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        front("f1");
        spawn("n1", 0);
        plot("n1");
        // hit at WAIT cycle 3
        repeat (3) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("hit_score", 32'(ldv), 32'(L_SCORE));
        hs("hit_score_hs", L_SCORE, 3);
        spawn("n2", 1);
        plot("n2");
        // miss: ten silent WAIT cycles then SPAWN
        for (int i = 0; i < 10; i++) begin
            check("miss_quiet", 32'(ldv), 32'(L_NONE));
            @(negedge clk);
        end
        spawn("n3", 2);
        plot("n3");
        done = 1'b1;
        gameover = 1'b1;
        @(negedge clk);
        done = 1'b0;
        gameover = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("over_draw", 32'(ldv), 32'(L_GO));
            check("over_dbusy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check("over_ld", 32'(ldv), 32'(L_NONE));
        check("over_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("over_hold", 32'(ldv), 32'(L_NONE));
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        front("f2");
        spawn("n4", 3);
        @(negedge clk);
        check("n4_plot", 32'(ldv), 32'(L_PLOT));
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_ld", 32'(ldv), 32'(L_NONE));
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_x", 32'(locX), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ld", 32'(ldv), 32'(L_NONE));
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        hs("wd_clear", L_BLACK, 0);
        hs("wd_bg", L_BG, 1);
        for (int i = 0; i < 20; i++) begin
            check("wd_osu", 32'(ldv), 32'(L_OSU));
            @(negedge clk);
        end
        check("wd_ld", 32'(ldv), 32'(L_NONE));
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_err", 32'(err), 32'd1);
        // stray status while idle is ignored
        stat = 4'b1111;
        @(negedge clk);
        stat = 4'b0000;
        check("stray_ld", 32'(ldv), 32'(L_NONE));
        check("stray_err", 32'(err), 32'd1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("err_clr", 32'(err), 32'd0);
        front("f3");
        spawn("n5", 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
